game_ctrl: RTL and testbench

- Two-player reaction game controller that produces the game status shown by the VGA display.
- Drives the display's state, score0, score1 and cnt0 inputs directly.
- Runs a seconds countdown, then awaits the first player hit, awards points, detects false starts and timeouts, and declares game over at a target score.
- Button inputs arrive already debounced and one-pulsed by the existing input stage.

---
 rtl/game_ctrl.sv | 176 +++++++++++++++++
 tb/tb_game_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Two-player reaction game controller: countdown, first-hit scoring, false-start
// and timeout detection, game over at a target score. All outputs registered.
module game_ctrl #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int CNT_START     = 3,
  parameter int PLAY_TIMEOUT  = 5,
  parameter int POINT_HOLD    = 2,
  parameter int WIN_SCORE     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit0,
  input  logic       hit1,
  output logic [2:0] state,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic [3:0] cnt0,
  output logic [1:0] last_pt
);

  localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [1:0] PT_NONE = 2'b00;
  localparam logic [1:0] PT_P0   = 2'b01;
  localparam logic [1:0] PT_P1   = 2'b10;

  state_t          state_q, state_d;
  logic [3:0]      score0_q, score0_d;
  logic [3:0]      score1_q, score1_d;
  logic [3:0]      cnt0_q, cnt0_d;
  logic [1:0]      last_pt_q, last_pt_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick;
  logic [3:0]      cnt_inc;

  // Scores saturate at the winning value and never wrap.
  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s < 4'(WIN_SCORE)) ? s + 4'd1 : s;
  endfunction

  assign tick    = (tick_cnt_q == TW'(TICKS_PER_SEC - 1));
  assign cnt_inc = cnt0_q + 4'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    score0_d  = score0_q;
    score1_d  = score1_q;
    cnt0_d    = cnt0_q;
    last_pt_d = last_pt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COUNT;
          score0_d  = 4'd0;
          score1_d  = 4'd0;
          last_pt_d = PT_NONE;
          cnt0_d    = 4'(CNT_START);
        end
      end
      COUNT: begin
        // A hit before PLAY is a false start; it wins over a same-cycle tick.
        if (hit0 || hit1) begin
          state_d = POINT;
          cnt0_d  = 4'd0;
          if (hit0 && hit1) begin
            last_pt_d = PT_NONE;
          end else if (hit0) begin
            score1_d  = sat_inc(score1_q);
            last_pt_d = PT_P1;
          end else begin
            score0_d  = sat_inc(score0_q);
            last_pt_d = PT_P0;
          end
        end else if (tick) begin
          if (cnt0_q == 4'd1) begin
            state_d = PLAY;
            cnt0_d  = 4'd0;
          end else begin
            cnt0_d = cnt0_q - 4'd1;
          end
        end
      end
      PLAY: begin
        if (hit0 || hit1) begin
          state_d = POINT;
          cnt0_d  = 4'd0;
          if (hit0 && hit1) begin
            last_pt_d = PT_NONE;
          end else if (hit0) begin
            score0_d  = sat_inc(score0_q);
            last_pt_d = PT_P0;
          end else begin
            score1_d  = sat_inc(score1_q);
            last_pt_d = PT_P1;
          end
        end else if (tick) begin
          if (cnt_inc == 4'(PLAY_TIMEOUT)) begin
            state_d   = POINT;
            cnt0_d    = 4'd0;
            last_pt_d = PT_NONE;
          end else begin
            cnt0_d = cnt_inc;
          end
        end
      end
      POINT: begin
        if (tick) begin
          if (cnt_inc == 4'(POINT_HOLD)) begin
            if (score0_q == 4'(WIN_SCORE) || score1_q == 4'(WIN_SCORE)) begin
              state_d = OVER;
              cnt0_d  = 4'd0;
            end else begin
              state_d = COUNT;
              cnt0_d  = 4'(CNT_START);
            end
          end else begin
            cnt0_d = cnt_inc;
          end
        end
      end
      OVER: begin
        cnt0_d = 4'd0;
        if (start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Restart the second counter on any transition so each state's first second is full.
    if (state_d != state_q || state_q == IDLE || state_q == OVER || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      score0_q   <= 4'd0;
      score1_q   <= 4'd0;
      cnt0_q     <= 4'd0;
      last_pt_q  <= PT_NONE;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      score0_q   <= score0_d;
      score1_q   <= score1_d;
      cnt0_q     <= cnt0_d;
      last_pt_q  <= last_pt_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign state   = state_q;
  assign score0  = score0_q;
  assign score1  = score1_q;
  assign cnt0    = cnt0_q;
  assign last_pt = last_pt_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a 10-cycle second; expected values are hand-derived.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hit0 = 1'b0;
  logic       hit1 = 1'b0;
  logic [2:0] state;
  logic [3:0] score0;
  logic [3:0] score1;
  logic [3:0] cnt0;
  logic [1:0] last_pt;

  int vectors = 0;
  int miscompares = 0;

  game_ctrl #(
    .TICKS_PER_SEC(10),
    .CNT_START(3),
    .PLAY_TIMEOUT(5),
    .POINT_HOLD(2),
    .WIN_SCORE(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .hit0(hit0),
    .hit1(hit1),
    .state(state),
    .score0(score0),
    .score1(score1),
    .cnt0(cnt0),
    .last_pt(last_pt)
  );

  always #5 clk = ~clk;

  // Advance n clock edges; inputs change and outputs are sampled 1 time unit after each edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] st, input logic [3:0] s0,
                           input logic [3:0] s1, input logic [3:0] c, input logic [3:0] lp);
    check({tag, ".state"}, 4'(state), st);
    check({tag, ".score0"}, score0, s0);
    check({tag, ".score1"}, score1, s1);
    check({tag, ".cnt0"}, cnt0, c);
    check({tag, ".last_pt"}, 4'(last_pt), lp);
  endtask

  initial begin
    // Reset and idle: hits are ignored.
    cyc(2);
    rst = 1'b0;
    check_all("reset", 0, 0, 0, 0, 0);
    hit0 = 1'b1; hit1 = 1'b1; cyc(1); hit0 = 1'b0; hit1 = 1'b0;
    check_all("idle_hits", 0, 0, 0, 0, 0);
    cyc(12);
    check_all("idle_hold", 0, 0, 0, 0, 0);

    // Countdown 3,2,1 at 10 cycles each, then PLAY.
    start = 1'b1; cyc(1); start = 1'b0;
    check_all("count_entry", 1, 0, 0, 3, 0);
    cyc(9);  check("count3_last", cnt0, 3);
    cyc(1);  check("count2", cnt0, 2);
    cyc(10); check("count1", cnt0, 1);
    cyc(10); check_all("play_entry", 2, 0, 0, 0, 0);
    start = 1'b1; cyc(1); start = 1'b0;
    check("start_ignored_play", 4'(state), 2);
    cyc(9);  check("play1", cnt0, 1);
    cyc(10); check("play2", cnt0, 2);
    cyc(20); check_all("play4", 2, 0, 0, 4, 0);
    cyc(10); check_all("timeout", 3, 0, 0, 0, 0);
    cyc(10); check_all("point_hold1", 3, 0, 0, 1, 0);
    cyc(9);  check("point_hold_end", 4'(state), 3);
    cyc(1);  check_all("recount", 1, 0, 0, 3, 0);

    // Scoring in PLAY.
    cyc(30); check("play_again", 4'(state), 2);
    cyc(7);
    hit1 = 1'b1; cyc(1); hit1 = 1'b0;
    check_all("hit1_play", 3, 0, 1, 0, 2);
    cyc(20); check("back_count_a", 4'(state), 1);
    cyc(30);
    hit0 = 1'b1; hit1 = 1'b1; cyc(1); hit0 = 1'b0; hit1 = 1'b0;
    check_all("both_play", 3, 0, 1, 0, 0);

    // False starts in COUNT.
    cyc(20); check("back_count_b", 4'(state), 1);
    cyc(10); check("false_at2", cnt0, 2);
    hit0 = 1'b1; cyc(1); hit0 = 1'b0;
    check_all("false_hit0", 3, 0, 2, 0, 2);
    cyc(20);
    hit0 = 1'b1; hit1 = 1'b1; cyc(1); hit0 = 1'b0; hit1 = 1'b0;
    check_all("false_both", 3, 0, 2, 0, 0);

    // Hit beats the final countdown tick, and hit beats the timeout tick.
    cyc(20);
    cyc(29); check("pre_tick_count", cnt0, 1);
    hit1 = 1'b1; cyc(1); hit1 = 1'b0;
    check_all("hit_over_tick_count", 3, 1, 2, 0, 1);
    cyc(20);
    cyc(30);
    cyc(49); check_all("pre_timeout", 2, 1, 2, 4, 1);
    hit0 = 1'b1; cyc(1); hit0 = 1'b0;
    check_all("hit_over_timeout", 3, 2, 2, 0, 1);

    // Game over: fresh game, player 0 wins five rounds.
    rst = 1'b1; cyc(1); rst = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(30);
      cyc(3);
      hit0 = 1'b1; cyc(1); hit0 = 1'b0;
      check("win_round_score", score0, 4'(i + 1));
      if (i < 4) begin
        cyc(20); check("win_round_recount", 4'(state), 1);
      end
    end
    cyc(19); check("over_pending", 4'(state), 3);
    cyc(1);  check_all("over", 4, 5, 0, 0, 1);
    hit0 = 1'b1; cyc(1); hit0 = 1'b0;
    check_all("over_hit", 4, 5, 0, 0, 1);
    cyc(15); check("over_hold", 4'(state), 4);
    start = 1'b1; cyc(1); start = 1'b0;
    check_all("over_to_idle", 0, 5, 0, 0, 1);
    start = 1'b1; cyc(1); start = 1'b0;
    check_all("restart", 1, 0, 0, 3, 0);

    // Reset mid-operation: score0=3, PLAY, tick counter half-way.
    for (int i = 0; i < 3; i++) begin
      cyc(30);
      hit0 = 1'b1; cyc(1); hit0 = 1'b0;
      cyc(20);
    end
    cyc(30);
    cyc(5);
    check_all("pre_reset", 2, 3, 0, 0, 1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    check_all("mid_reset", 0, 0, 0, 0, 0);
    start = 1'b1; cyc(1); start = 1'b0;
    check("post_reset_start", cnt0, 3);
    cyc(9);  check("post_reset_full", cnt0, 3);
    cyc(1);  check("post_reset_dec", cnt0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
